// File: rtl/sys_timer_ctrl_master.sv
// Avalon-MM master that programs, services and snapshots the interval timer.
// Command > irq > snapshot arbitration; bus outputs come from registers.
module sys_timer_ctrl_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_start,
  input  logic [31:0] cmd_period,
  input  logic        cmd_continuous,
  input  logic        cmd_irq_en,
  input  logic        snap_req,
  output logic        snap_valid,
  output logic [31:0] snap_value,
  output logic        timeout_pulse,
  output logic [15:0] timeout_count,
  output logic        timer_running,
  output logic [2:0]  av_address,
  output logic        av_chipselect,
  output logic        av_write_n,
  output logic [15:0] av_writedata,
  input  logic [15:0] av_readdata,
  input  logic        irq
);

  typedef enum logic [3:0] {
    S_IDLE, S_RUN, S_WR_STOP, S_WR_PL,
    S_WR_PH, S_WR_CTRL, S_WR_CLR, S_WR_STAT,
    S_WR_SNAP, S_RD_SL, S_RD_SH, S_CAP_H
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_cs;
  logic        w_wn;
  logic [2:0]  w_addr;
  logic [15:0] w_wd;

  logic        r_cmd_ready;
  logic        r_start;
  logic [31:0] r_period;
  logic        r_cont;
  logic        r_irq_en;
  logic        r_snap_pend;
  logic        r_snap_valid;
  logic [31:0] r_snap;
  logic        r_pulse;
  logic [15:0] r_count;
  logic        r_running;
  logic [2:0]  r_addr;
  logic        r_cs;
  logic        r_wn;
  logic [15:0] r_wd;

  assign w_accept = cmd_valid & r_cmd_ready;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_RUN: begin
        if (w_accept)
          w_next = S_WR_STOP;
        else if (irq)
          w_next = S_WR_STAT;
        else if (r_snap_pend)
          w_next = S_WR_SNAP;
      end
      S_WR_STOP: w_next = r_start ? S_WR_PL : S_WR_CLR;
      S_WR_PL:   w_next = S_WR_PH;
      S_WR_PH:   w_next = S_WR_CTRL;
      S_WR_CTRL: w_next = S_RUN;
      S_WR_CLR:  w_next = S_IDLE;
      S_WR_STAT: begin
        w_next = (r_running & r_cont) ? S_RUN : S_IDLE;
      end
      S_WR_SNAP: w_next = S_RD_SL;
      S_RD_SL:   w_next = S_RD_SH;
      S_RD_SH:   w_next = S_CAP_H;
      S_CAP_H:   w_next = r_running ? S_RUN : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Bus fields for the state being entered, registered at the same edge.
  always_comb begin
    w_cs   = 1'b0;
    w_wn   = 1'b1;
    w_addr = 3'd0;
    w_wd   = 16'd0;
    unique case (w_next)
      S_WR_STOP: begin
        w_cs = 1'b1; w_wn = 1'b0;
        w_addr = 3'd1; w_wd = 16'h0008;
      end
      S_WR_PL: begin
        w_cs = 1'b1; w_wn = 1'b0;
        w_addr = 3'd2; w_wd = r_period[15:0];
      end
      S_WR_PH: begin
        w_cs = 1'b1; w_wn = 1'b0;
        w_addr = 3'd3; w_wd = r_period[31:16];
      end
      S_WR_CTRL: begin
        w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd1;
        w_wd = {13'd0, 1'b1, r_cont, r_irq_en};
      end
      S_WR_CLR: begin
        w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd1;
      end
      S_WR_STAT: begin
        w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd0;
      end
      S_WR_SNAP: begin
        w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd4;
      end
      S_RD_SL: begin
        w_cs = 1'b1; w_addr = 3'd4;
      end
      S_RD_SH: begin
        w_cs = 1'b1; w_addr = 3'd5;
      end
      default: begin
        w_cs = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cmd_ready  <= 1'b0;
      r_start      <= 1'b0;
      r_period     <= 32'd0;
      r_cont       <= 1'b0;
      r_irq_en     <= 1'b0;
      r_snap_pend  <= 1'b0;
      r_snap_valid <= 1'b0;
      r_snap       <= 32'd0;
      r_pulse      <= 1'b0;
      r_count      <= 16'd0;
      r_running    <= 1'b0;
      r_addr       <= 3'd0;
      r_cs         <= 1'b0;
      r_wn         <= 1'b1;
      r_wd         <= 16'd0;
    end else begin
      r_state     <= w_next;
      r_addr      <= w_addr;
      r_cs        <= w_cs;
      r_wn        <= w_wn;
      r_wd        <= w_wd;
      r_cmd_ready <= (w_next == S_IDLE) || (w_next == S_RUN);
      if (w_accept) begin
        r_start  <= cmd_start;
        r_period <= cmd_period;
        r_cont   <= cmd_continuous;
        r_irq_en <= cmd_irq_en;
      end
      // A request landing on the entry edge still counts as a new one.
      r_snap_pend <= snap_req |
                     (r_snap_pend & (w_next != S_WR_SNAP));
      r_pulse <= (r_state == S_WR_STAT);
      if (r_state == S_WR_STAT)
        r_count <= r_count + 16'd1;
      if (r_state == S_RD_SH)
        r_snap[15:0] <= av_readdata;
      if (r_state == S_CAP_H)
        r_snap[31:16] <= av_readdata;
      r_snap_valid <= (r_state == S_CAP_H);
      if (r_state == S_WR_CTRL)
        r_running <= 1'b1;
      else if (r_state == S_WR_CLR)
        r_running <= 1'b0;
      else if (r_state == S_WR_STAT && !r_cont)
        r_running <= 1'b0;
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign snap_valid    = r_snap_valid;
  assign snap_value    = r_snap;
  assign timeout_pulse = r_pulse;
  assign timeout_count = r_count;
  assign timer_running = r_running;
  assign av_address    = r_addr;
  assign av_chipselect = r_cs;
  assign av_write_n    = r_wn;
  assign av_writedata  = r_wd;

endmodule

// File: tb/tb_sys_timer_ctrl_master.sv
// Bench for sys_timer_ctrl_master with a behavioural interval-timer slave.
// Bus traffic and snapshots are logged and compared with expected sequences.
module tb_sys_timer_ctrl_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_start = 1'b0;
  logic [31:0] cmd_period = 32'd0;
  logic        cmd_continuous = 1'b0;
  logic        cmd_irq_en = 1'b0;
  logic        snap_req = 1'b0;
  logic        snap_valid;
  logic [31:0] snap_value;
  logic        timeout_pulse;
  logic [15:0] timeout_count;
  logic        timer_running;
  logic [2:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        irq;

  sys_timer_ctrl_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_period(cmd_period),
    .cmd_continuous(cmd_continuous),
    .cmd_irq_en(cmd_irq_en),
    .snap_req(snap_req), .snap_valid(snap_valid),
    .snap_value(snap_value),
    .timeout_pulse(timeout_pulse),
    .timeout_count(timeout_count),
    .timer_running(timer_running),
    .av_address(av_address),
    .av_chipselect(av_chipselect),
    .av_write_n(av_write_n),
    .av_writedata(av_writedata),
    .av_readdata(av_readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wide = 0;
  logic pulse_prev = 1'b0;
  logic sv_prev = 1'b0;

  // Entry: [51:20] cycle, [19:17] addr, [16] write_n, [15:0] data
  logic [51:0] blog[$];
  logic [51:0] exq[$];
  logic [63:0] sev[$];

  // Slave: counts period..0, sets TO at the wrap, irq follows TO.
  logic [31:0] s_cnt = 0;
  logic [31:0] s_per = 0;
  logic [31:0] s_snap = 0;
  logic        s_to = 0;
  logic        s_run = 0;
  logic        s_cont = 0;
  logic [15:0] s_rd = 0;
  int          s_toev = 0;
  logic [31:0] snapq[$];

  assign irq = s_to;
  assign av_readdata = s_rd;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_run) begin
      if (s_cnt == 0) begin
        s_to <= 1'b1;
        s_toev <= s_toev + 1;
        s_cnt <= s_per;
        if (!s_cont) s_run <= 1'b0;
      end else begin
        s_cnt <= s_cnt - 1;
      end
    end
    if (av_chipselect && !av_write_n) begin
      case (av_address)
        3'd0: s_to <= 1'b0;
        3'd1: begin
          s_cont <= av_writedata[1];
          if (av_writedata[3]) s_run <= 1'b0;
          else if (av_writedata[2]) begin
            s_run <= 1'b1;
            s_cnt <= s_per;
          end
        end
        3'd2: s_per[15:0] <= av_writedata;
        3'd3: begin
          s_per[31:16] <= av_writedata;
          s_cnt <= {av_writedata, s_per[15:0]};
        end
        3'd4: begin
          s_snap <= s_cnt;
          snapq.push_back(s_cnt);
        end
        default: ;
      endcase
    end
    if (av_chipselect && av_write_n)
      s_rd <= (av_address == 3'd5) ? s_snap[31:16] :
              (av_address == 3'd4) ? s_snap[15:0] :
              {15'd0, s_to};
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (av_chipselect)
        blog.push_back({32'(cyc), av_address,
                        av_write_n, av_writedata});
      if (snap_valid)
        sev.push_back({32'(cyc), snap_value});
      if ((timeout_pulse && pulse_prev) ||
          (snap_valid && sv_prev))
        wide <= wide + 1;
      pulse_prev <= timeout_pulse;
      sv_prev <= snap_valid;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic e(input int off, input logic [2:0] a,
                   input logic wn, input logic [15:0] d);
    exq.push_back({32'(off), a, wn, d});
  endtask

  task automatic e_start(input int off, input logic [31:0] p,
                         input logic co, input logic ie);
    e(off, 3'd1, 1'b0, 16'h0008);
    e(off + 1, 3'd2, 1'b0, p[15:0]);
    e(off + 2, 3'd3, 1'b0, p[31:16]);
    e(off + 3, 3'd1, 1'b0, {13'd0, 1'b1, co, ie});
  endtask

  task automatic check_log(input string tag, input int c0);
    chk({tag, "_len"}, 64'(blog.size()), 64'(exq.size()));
    for (int i = 0; i < exq.size() && i < blog.size(); i++)
      chk(tag, 64'(blog[i]),
          64'({exq[i][51:20] + 32'(c0), exq[i][19:0]}));
    exq.delete();
  endtask

  task automatic send(input logic st, input logic [31:0] p,
                      input logic co, input logic ie,
                      output int c0);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", 64'(n < 20), 64'd1);
    cmd_start = st;
    cmd_period = p;
    cmd_continuous = co;
    cmd_irq_en = ie;
    cmd_valid = 1'b1;
    c0 = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_cnt(input string tag,
                          input logic [31:0] v);
    int n;
    n = 0;
    while (!(s_run && s_cnt == v) && n < 300) begin
      tick();
      n++;
    end
    chk(tag, 64'(n < 300), 64'd1);
  endtask

  initial begin
    int c0;
    int cr;
    int n;
    int tc0;
    int nreq;
    logic [31:0] rp;
    int sc[$];

    repeat (3) tick();
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_cs", 64'(av_chipselect), 64'd0);
    chk("rst_wn", 64'(av_write_n), 64'd1);
    chk("rst_run", 64'(timer_running), 64'd0);
    chk("rst_count", 64'(timeout_count), 64'd0);
    chk("rst_sv", 64'(snap_valid), 64'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);
    chk("post_rst_cs", 64'(av_chipselect), 64'd0);

    // Start sequence
    blog.delete();
    send(1'b1, 32'h0001_86A0, 1'b1, 1'b1, c0);
    repeat (4) tick();
    chk("start_ready", 64'(cmd_ready), 64'd1);
    chk("start_run", 64'(timer_running), 64'd1);
    e_start(1, 32'h0001_86A0, 1'b1, 1'b1);
    check_log("start_bus", c0);

    // Stop sequence
    blog.delete();
    send(1'b0, 32'd0, 1'b0, 1'b0, c0);
    repeat (2) tick();
    chk("stop_run", 64'(timer_running), 64'd0);
    chk("stop_ready", 64'(cmd_ready), 64'd1);
    e(1, 3'd1, 1'b0, 16'h0008);
    e(2, 3'd1, 1'b0, 16'h0000);
    check_log("stop_bus", c0);

    // Continuous period 9: a timeout every 10 cycles
    tc0 = s_toev;
    blog.delete();
    send(1'b1, 32'd9, 1'b1, 1'b1, c0);
    n = 0;
    do begin
      tick();
      n++;
      sc.delete();
      foreach (blog[i])
        if (blog[i][19:16] == 4'b0000)
          sc.push_back(int'(blog[i][51:20]));
    end while (sc.size() < 3 && n < 80);
    chk("cont_wait", 64'(n < 80), 64'd1);
    chk("cont_nstat", 64'(sc.size()), 64'd3);
    if (sc.size() >= 3) begin
      chk("cont_gap1", 64'(sc[1] - sc[0]), 64'd10);
      chk("cont_gap2", 64'(sc[2] - sc[1]), 64'd10);
    end
    chk("cont_count", 64'(timeout_count), 64'(16'(tc0 + 3)));
    send(1'b0, 32'd0, 1'b0, 1'b0, c0);
    repeat (5) tick();
    chk("cont_pulse_width", 64'(wide), 64'd0);

    // One-shot period 5: single service, then idle bus
    tc0 = s_toev;
    blog.delete();
    send(1'b1, 32'd5, 1'b0, 1'b1, c0);
    repeat (40) tick();
    e_start(1, 32'd5, 1'b0, 1'b1);
    e(12, 3'd0, 1'b0, 16'h0000);
    check_log("oneshot_bus", c0);
    chk("oneshot_run", 64'(timer_running), 64'd0);
    chk("oneshot_ready", 64'(cmd_ready), 64'd1);
    chk("oneshot_count", 64'(timeout_count),
        64'(16'(tc0 + 1)));

    // Snapshot while the counter passes 0x0001_2345
    send(1'b1, 32'h0001_2350, 1'b1, 1'b0, c0);
    wait_cnt("snap_wait", 32'h0001_2347);
    blog.delete();
    sev.delete();
    snap_req = 1'b1;
    cr = cyc;
    tick();
    snap_req = 1'b0;
    repeat (6) tick();
    e(2, 3'd4, 1'b0, 16'h0000);
    e(3, 3'd4, 1'b1, 16'h0000);
    e(4, 3'd5, 1'b1, 16'h0000);
    check_log("snap_bus", cr);
    chk("snap_n", 64'(sev.size()), 64'd1);
    if (sev.size() >= 1) begin
      chk("snap_value", 64'(sev[0][31:0]), 64'h0001_2345);
      chk("snap_cycle", 64'(sev[0][63:32]), 64'(cr + 6));
    end
    send(1'b0, 32'd0, 1'b0, 1'b0, c0);
    repeat (5) tick();

    // Random snapshots interleaved with timeouts
    rp = 32'($urandom_range(30, 60));
    send(1'b1, rp, 1'b1, 1'b1, c0);
    sev.delete();
    snapq.delete();
    nreq = 0;
    for (int k = 0; k < 15; k++) begin
      repeat ($urandom_range(8, 25)) tick();
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      nreq++;
    end
    repeat (20) tick();
    send(1'b0, 32'd0, 1'b0, 1'b0, c0);
    repeat (10) tick();
    chk("rnd_nsnap", 64'(sev.size()), 64'(nreq));
    chk("rnd_nmodel", 64'(snapq.size()), 64'(nreq));
    for (int i = 0; i < sev.size() && i < snapq.size(); i++)
      chk("rnd_snap_value", 64'(sev[i][31:0]), 64'(snapq[i]));
    chk("rnd_count", 64'(timeout_count), 64'(16'(s_toev)));
    chk("rnd_width", 64'(wide), 64'd0);
    chk("rnd_run", 64'(timer_running), 64'd0);

    // Stop command in the same cycle irq rises
    send(1'b1, 32'd20, 1'b1, 1'b1, c0);
    wait_cnt("irq_wait", 32'd0);
    tick();
    blog.delete();
    send(1'b0, 32'd0, 1'b0, 1'b0, c0);
    repeat (6) tick();
    e(1, 3'd1, 1'b0, 16'h0008);
    e(2, 3'd1, 1'b0, 16'h0000);
    e(4, 3'd0, 1'b0, 16'h0000);
    check_log("stop_irq_bus", c0);
    chk("stop_irq_run", 64'(timer_running), 64'd0);
    chk("stop_irq_ready", 64'(cmd_ready), 64'd1);
    chk("stop_irq_count", 64'(timeout_count),
        64'(16'(s_toev)));

    // Reset during WR_PH
    rp = $urandom();
    send(1'b1, rp, 1'b1, 1'b1, c0);
    repeat (2) tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_cs", 64'(av_chipselect), 64'd0);
    chk("mid_rst_wn", 64'(av_write_n), 64'd1);
    chk("mid_rst_addr", 64'(av_address), 64'd0);
    chk("mid_rst_wd", 64'(av_writedata), 64'd0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd0);
    chk("mid_rst_count", 64'(timeout_count), 64'd0);
    chk("mid_rst_snap", 64'(snap_value), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("rel_ready", 64'(cmd_ready), 64'd1);
    chk("rel_cs", 64'(av_chipselect), 64'd0);
    chk("rel_run", 64'(timer_running), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
